// File: rtl/umi_pkg.sv
// ----------------------------------------------------------------------------
// umi_pkg
// Shared UMI definitions for the flexible-width FIFO core:
//   - command field offsets/widths (opcode, SIZE, LEN, EOM)
//   - opcode constants
//   - umi_bytes(): total byte count of a transaction, (LEN+1) << SIZE
// ----------------------------------------------------------------------------
package umi_pkg;

    localparam int UMI_OPCODE_LSB = 0;
    localparam int UMI_OPCODE_W   = 5;
    localparam int UMI_SIZE_LSB   = 5;
    localparam int UMI_SIZE_W     = 3;
    localparam int UMI_LEN_LSB    = 8;
    localparam int UMI_LEN_W      = 8;
    localparam int UMI_EOM_BIT    = 22;

    typedef enum logic [4:0] {
        UMI_INVALID    = 5'h00,
        UMI_REQ_READ   = 5'h01,
        UMI_RESP_READ  = 5'h02,
        UMI_REQ_WRITE  = 5'h03,
        UMI_RESP_WRITE = 5'h04,
        UMI_REQ_POSTED = 5'h05
    } umi_opcode_e;

    // Largest case is 256 << 7 = 32768, which still fits in 16 bits.
    function automatic logic [15:0] umi_bytes(input logic [2:0] size,
                                              input logic [7:0] len);
        return (16'(len) + 16'd1) << size;
    endfunction

endpackage

// File: rtl/umi_fifo_flex_store.sv
// ----------------------------------------------------------------------------
// umi_fifo_flex_store
// Single-clock synchronous FIFO holding packed UMI transactions.
// Ports:
//   clk     in        clock
//   nreset  in        synchronous active-high reset (clears pointers)
//   push    in        write wdata (ignored while full unless popping too)
//   pop     in        drop the head entry (ignored while empty)
//   wdata   in  DW    entry to write
//   rdata   out DW    head entry (combinational read)
//   full    out       storage full
//   empty   out       storage empty
// ----------------------------------------------------------------------------
module umi_fifo_flex_store
    import umi_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign rdata = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + (PW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (PW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/umi_fifo_flex_core.sv
// ----------------------------------------------------------------------------
// umi_fifo_flex_core
// Single-clock UMI FIFO with IDW -> ODW data-width conversion. Transactions
// larger than the output port are split into ODW-sized UMI transactions.
// Ports:
//   clk, nreset            clock, synchronous active-high reset
//   bypass                 1 = combinational in->out path, storage unused
//   chaosmode              1 = LFSR-driven throttling of in_ready/out_valid
//   fifo_full, fifo_empty  storage flags
//   umi_in_*               input UMI port (valid/ready, cmd, dst, src, data)
//   umi_out_*              output UMI port (valid/ready, cmd, dst, src, data)
//   vdd, vss               supply placeholders, no function
// ----------------------------------------------------------------------------
module umi_fifo_flex_core
    import umi_pkg::*;
#(
    parameter int IDW   = 128,
    parameter int ODW   = 32,
    parameter int CW    = 32,
    parameter int AW    = 64,
    parameter int DEPTH = 512,
    parameter int SPLIT = 0
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           bypass,
    input  logic           chaosmode,
    output logic           fifo_full,
    output logic           fifo_empty,
    input  logic           umi_in_valid,
    output logic           umi_in_ready,
    input  logic [CW-1:0]  umi_in_cmd,
    input  logic [AW-1:0]  umi_in_dstaddr,
    input  logic [AW-1:0]  umi_in_srcaddr,
    input  logic [IDW-1:0] umi_in_data,
    output logic           umi_out_valid,
    input  logic           umi_out_ready,
    output logic [CW-1:0]  umi_out_cmd,
    output logic [AW-1:0]  umi_out_dstaddr,
    output logic [AW-1:0]  umi_out_srcaddr,
    output logic [ODW-1:0] umi_out_data,
    input  logic           vdd,
    input  logic           vss
);

    localparam int unsigned CB       = ODW / 8;
    localparam int          XW       = (IDW > ODW) ? IDW : ODW;
    localparam int          SW       = CW + 2*AW + IDW;
    localparam bit          CHUNK_OK = (IDW > ODW) || (SPLIT != 0);
    localparam logic [15:0] CB16     = 16'(CB);

    logic           unused_supply;
    assign unused_supply = vdd ^ vss;

    logic [15:0]    lfsr_q, lfsr_d;
    logic [15:0]    chunk_cnt_q, chunk_cnt_d;

    logic           st_push, st_pop, st_full, st_empty;
    logic [SW-1:0]  st_wdata, st_rdata;

    logic [CW-1:0]  src_cmd;
    logic [AW-1:0]  src_dst, src_src;
    logic [IDW-1:0] src_data;

    logic [2:0]     size;
    logic [7:0]     len;
    logic [15:0]    bytes, offset, remaining, n_bytes;
    logic           chunk_en, last_chunk, out_fire;
    logic           mask_in, mask_out;
    logic [31:0]    shamt;

    assign st_wdata   = {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};
    assign fifo_full  = st_full;
    assign fifo_empty = st_empty;

    umi_fifo_flex_store #(
        .DW    (SW),
        .DEPTH (DEPTH)
    ) u_store (
        .clk    (clk),
        .nreset (nreset),
        .push   (st_push),
        .pop    (st_pop),
        .wdata  (st_wdata),
        .rdata  (st_rdata),
        .full   (st_full),
        .empty  (st_empty)
    );

    // Head transaction: live input in bypass, FIFO head otherwise.
    always_comb begin
        if (bypass) begin
            src_cmd  = umi_in_cmd;
            src_dst  = umi_in_dstaddr;
            src_src  = umi_in_srcaddr;
            src_data = umi_in_data;
        end else begin
            {src_cmd, src_dst, src_src, src_data} = st_rdata;
        end
    end

    // Galois LFSR, taps x^16+x^14+x^13+x^11.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    // Chunk k starts at byte offset k*C; the count of bytes still owed
    // decides both the chunk LEN and whether this is the last chunk.
    always_comb begin
        size       = src_cmd[UMI_SIZE_LSB +: UMI_SIZE_W];
        len        = src_cmd[UMI_LEN_LSB +: UMI_LEN_W];
        bytes      = umi_bytes(size, len);
        chunk_en   = CHUNK_OK && (bytes > CB16);
        offset     = chunk_en ? 16'(32'(chunk_cnt_q) * CB) : 16'd0;
        remaining  = bytes - offset;
        last_chunk = !chunk_en || (remaining <= CB16);
        n_bytes    = (remaining < CB16) ? remaining : CB16;
        shamt      = 32'(offset) << 3;

        umi_out_cmd = src_cmd;
        if (chunk_en) begin
            umi_out_cmd[UMI_LEN_LSB +: UMI_LEN_W] = 8'((n_bytes >> size) - 16'd1);
            umi_out_cmd[UMI_EOM_BIT] = last_chunk ? src_cmd[UMI_EOM_BIT] : 1'b0;
        end
        umi_out_dstaddr = src_dst + AW'(offset);
        umi_out_srcaddr = src_src + AW'(offset);
        umi_out_data    = ODW'(XW'(src_data) >> shamt);
    end

    // Handshakes. In bypass one mask bit gates both sides so that an input
    // is only released together with its final output chunk.
    always_comb begin
        mask_in  = chaosmode & lfsr_q[0];
        mask_out = chaosmode & lfsr_q[1];
        if (bypass) begin
            umi_out_valid = umi_in_valid & ~mask_out;
            umi_in_ready  = umi_out_ready & last_chunk & ~mask_out;
        end else begin
            umi_out_valid = ~st_empty & ~mask_out;
            umi_in_ready  = ~st_full & ~mask_in;
        end
        out_fire = umi_out_valid & umi_out_ready;
        st_push  = umi_in_valid & umi_in_ready & ~bypass;
        st_pop   = out_fire & last_chunk & ~bypass;

        chunk_cnt_d = chunk_cnt_q;
        if (out_fire) begin
            chunk_cnt_d = last_chunk ? 16'd0 : chunk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            lfsr_q      <= 16'hACE1;
            chunk_cnt_q <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            chunk_cnt_q <= chunk_cnt_d;
        end
    end

endmodule

// File: tb/tb_umi_fifo_flex_core.sv
module tb_umi_fifo_flex_core;

    typedef struct {
        logic [31:0] cmd;
        logic [63:0] dst;
        logic [63:0] src;
        logic [31:0] data;
    } exp_t;

    logic         clk;
    logic         nreset;
    logic         bypass;
    logic         chaosmode;
    logic         umi_fifo_full, umi_fifo_empty;
    logic         umi_in_valid, umi_in_ready;
    logic [31:0]  umi_in_cmd;
    logic [63:0]  umi_in_dstaddr, umi_in_srcaddr;
    logic [127:0] umi_in_data;
    logic         umi_out_valid, umi_out_ready;
    logic [31:0]  umi_out_cmd;
    logic [63:0]  umi_out_dstaddr, umi_out_srcaddr;
    logic [31:0]  umi_out_data;

    logic         w_full, w_empty;
    logic         w_in_valid, w_in_ready;
    logic [31:0]  w_in_cmd;
    logic [63:0]  w_in_dst, w_in_src;
    logic [31:0]  w_in_data;
    logic         w_out_valid, w_out_ready;
    logic [31:0]  w_out_cmd;
    logic [63:0]  w_out_dst, w_out_src;
    logic [127:0] w_out_data;

    logic         rdy_rand, rdy_fixed, rnd_bit;
    int           total = 0;
    int           bad = 0;
    exp_t         exp_q[$];
    exp_t         mon_e;

    assign umi_out_ready = rdy_rand ? rnd_bit : rdy_fixed;

    umi_fifo_flex_core #(
        .IDW(128), .ODW(32), .CW(32), .AW(64), .DEPTH(4), .SPLIT(0)
    ) dut (
        .clk(clk), .nreset(nreset), .bypass(bypass), .chaosmode(chaosmode),
        .fifo_full(umi_fifo_full), .fifo_empty(umi_fifo_empty),
        .umi_in_valid(umi_in_valid), .umi_in_ready(umi_in_ready),
        .umi_in_cmd(umi_in_cmd), .umi_in_dstaddr(umi_in_dstaddr),
        .umi_in_srcaddr(umi_in_srcaddr), .umi_in_data(umi_in_data),
        .umi_out_valid(umi_out_valid), .umi_out_ready(umi_out_ready),
        .umi_out_cmd(umi_out_cmd), .umi_out_dstaddr(umi_out_dstaddr),
        .umi_out_srcaddr(umi_out_srcaddr), .umi_out_data(umi_out_data),
        .vdd(1'b1), .vss(1'b0)
    );

    umi_fifo_flex_core #(
        .IDW(32), .ODW(128), .CW(32), .AW(64), .DEPTH(4), .SPLIT(0)
    ) dut_wide (
        .clk(clk), .nreset(nreset), .bypass(1'b0), .chaosmode(1'b0),
        .fifo_full(w_full), .fifo_empty(w_empty),
        .umi_in_valid(w_in_valid), .umi_in_ready(w_in_ready),
        .umi_in_cmd(w_in_cmd), .umi_in_dstaddr(w_in_dst),
        .umi_in_srcaddr(w_in_src), .umi_in_data(w_in_data),
        .umi_out_valid(w_out_valid), .umi_out_ready(w_out_ready),
        .umi_out_cmd(w_out_cmd), .umi_out_dstaddr(w_out_dst),
        .umi_out_srcaddr(w_out_src), .umi_out_data(w_out_data),
        .vdd(1'b1), .vss(1'b0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rnd_bit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference model: expected output transactions from the chunking rules
    // with C = 4 bytes (32-bit output) and a 16-byte input beat.
    task automatic push_expected(input logic [31:0] c, input logic [63:0] d,
                                 input logic [63:0] s, input logic [127:0] dat);
        int   sz, ln, b, nch, n;
        exp_t e;
        sz = int'(c[7:5]);
        ln = int'(c[15:8]);
        b  = (ln + 1) << sz;
        if (b > 4) begin
            nch = (b + 3) / 4;
            for (int k = 0; k < nch; k++) begin
                n = (b - 4*k < 4) ? (b - 4*k) : 4;
                e.cmd        = c;
                e.cmd[15:8]  = 8'((n >> sz) - 1);
                e.cmd[22]    = (k == nch - 1) ? c[22] : 1'b0;
                e.dst        = d + 64'(4*k);
                e.src        = s + 64'(4*k);
                e.data       = (k < 4) ? dat[32*k +: 32] : 32'h0;
                exp_q.push_back(e);
            end
        end else begin
            e.cmd  = c;
            e.dst  = d;
            e.src  = s;
            e.data = dat[31:0];
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every output handshake is compared against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!nreset && umi_out_valid && umi_out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_unexpected got cmd=%h dst=%h data=%h",
                             umi_out_cmd, umi_out_dstaddr, umi_out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (umi_out_cmd !== mon_e.cmd || umi_out_dstaddr !== mon_e.dst ||
                        umi_out_srcaddr !== mon_e.src || umi_out_data !== mon_e.data) begin
                        bad++;
                        $display("FAIL out_txn got cmd=%h dst=%h src=%h data=%h want cmd=%h dst=%h src=%h data=%h",
                                 umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data,
                                 mon_e.cmd, mon_e.dst, mon_e.src, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    task automatic send(input logic [31:0] c, input logic [63:0] d,
                        input logic [63:0] s, input logic [127:0] dat);
        int n;
        bit ok;
        @(posedge clk);
        #1;
        push_expected(c, d, s, dat);
        umi_in_cmd     = c;
        umi_in_dstaddr = d;
        umi_in_srcaddr = s;
        umi_in_data    = dat;
        umi_in_valid   = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (umi_in_ready) ok = 1'b1;
            else n++;
        end
        @(posedge clk);
        #1;
        umi_in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout cmd=%h waited=%0d limit=500", c, n);
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !umi_fifo_empty) && n < 5000) begin
            @(negedge clk);
            #2;
            n++;
        end
        total++;
        if (exp_q.size() != 0 || !umi_fifo_empty) begin
            bad++;
            $display("FAIL %s pending=%0d empty=%0b want pending=0 empty=1",
                     nm, exp_q.size(), umi_fifo_empty);
        end
    endtask

    task automatic rand_txn(output logic [31:0] c, output logic [63:0] d,
                            output logic [63:0] s, output logic [127:0] dat);
        int sz;
        sz = $urandom_range(0, 2);
        c  = $urandom;
        c[7:5]  = 3'(sz);
        c[15:8] = 8'($urandom_range(0, (16 >> sz) - 1));
        d   = {$urandom, $urandom};
        s   = {$urandom, $urandom};
        dat = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        logic [31:0]  c;
        logic [63:0]  d, s;
        logic [127:0] dat;
        logic [31:0]  wd;
        int           n;

        nreset = 1'b1;
        bypass = 1'b0;
        chaosmode = 1'b0;
        rdy_rand = 1'b0;
        rdy_fixed = 1'b0;
        umi_in_valid = 1'b0;
        umi_in_cmd = '0;
        umi_in_dstaddr = '0;
        umi_in_srcaddr = '0;
        umi_in_data = '0;
        w_in_valid = 1'b0;
        w_in_cmd = '0;
        w_in_dst = '0;
        w_in_src = '0;
        w_in_data = '0;
        w_out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", 128'(umi_fifo_empty), 128'd1);
        chk("rst_full", 128'(umi_fifo_full), 128'd0);
        chk("rst_out_valid", 128'(umi_out_valid), 128'd0);
        chk("rst_in_ready", 128'(umi_in_ready), 128'd1);
        nreset = 1'b0;

        // Directed chunking cases.
        rdy_fixed = 1'b1;
        dat = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        send(32'h0040_0F03, 64'h100, 64'h200, dat);
        send(32'h0000_0141, 64'h300, 64'h400, {96'h0, 32'h1234_5678} | {64'h0, 32'h9ABC_DEF0, 32'h0});
        send(32'h0040_0041, 64'h500, 64'h600, 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888);
        drain("drain_directed");

        // Fill a 4-deep FIFO with output stalled, then release one entry.
        rdy_fixed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(32'h0000_0003, 64'(i), 64'(i + 16), 128'(i * 7 + 1));
        end
        chk("full_set", 128'(umi_fifo_full), 128'd1);
        chk("full_in_ready", 128'(umi_in_ready), 128'd0);
        rdy_fixed = 1'b1;
        @(posedge clk);
        #1;
        rdy_fixed = 1'b0;
        chk("full_clear_after_pop", 128'(umi_fifo_full), 128'd0);
        rdy_fixed = 1'b1;
        drain("drain_full");

        // Reset in the middle of a 4-chunk transaction.
        rdy_fixed = 1'b0;
        send(32'h0040_0F03, 64'h100, 64'h200, {$urandom, $urandom, $urandom, $urandom});
        rdy_fixed = 1'b1;
        n = 0;
        while (exp_q.size() > 2 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("midreset_reached_chunk2", 128'(exp_q.size()), 128'd2);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_out_valid", 128'(umi_out_valid), 128'd0);
        chk("midreset_empty", 128'(umi_fifo_empty), 128'd1);
        exp_q.delete();
        nreset = 1'b0;

        // Widening instance: no split, zero-extended data.
        wd = $urandom;
        c  = 32'h0040_0302;
        @(posedge clk);
        #1;
        w_in_cmd = c;
        w_in_dst = 64'h0123_4567_89AB_CDE0;
        w_in_src = 64'h0000_0000_0000_0040;
        w_in_data = wd;
        w_in_valid = 1'b1;
        n = 0;
        while (!w_in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wide_in_ready", 128'(w_in_ready), 128'd1);
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        chk("wide_out_valid", 128'(w_out_valid), 128'd1);
        chk("wide_cmd", 128'(w_out_cmd), 128'(c));
        chk("wide_data", w_out_data, {96'h0, wd});
        chk("wide_dst", 128'(w_out_dst), 128'h0123_4567_89AB_CDE0);
        chk("wide_src", 128'(w_out_src), 128'h40);
        chk("wide_full", 128'(w_full), 128'd0);
        w_out_ready = 1'b1;
        @(posedge clk);
        #1;
        w_out_ready = 1'b0;
        chk("wide_empty_after_pop", 128'(w_empty), 128'd1);

        // Randomized traffic: plain, chaos, chaos+bypass.
        rdy_rand = 1'b1;
        for (int p = 0; p < 3; p++) begin
            chaosmode = (p > 0);
            bypass = (p == 2);
            for (int i = 0; i < 250; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                rand_txn(c, d, s, dat);
                send(c, d, s, dat);
            end
            drain("drain_random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
